// File: rtl/div_repsub_if.sv
// div_repsub_if: operand/result bus for the repeated-subtraction divider.
//
// Parameter:
//   W          operand/result width (unsigned)
// Signals:
//   start      begin operation (driven by master)
//   data_in    operand bus: dividend, then divisor on the next cycle
//   quotient   quotient register (from divider)
//   remainder  running remainder register (from divider)
//   busy       divider is loading or subtracting
//   done       result valid
//   err        divide-by-zero flag, present only when DIV_ZERO_ERR_EN is defined
//
// Modports: master (harness side), slave (divider side).
interface div_repsub_if #(
    parameter int unsigned W = 16
) ();
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
`ifdef DIV_ZERO_ERR_EN
    logic         err;
`endif

    modport master (
        output start,
        output data_in,
        input  quotient,
        input  remainder,
        input  busy,
`ifdef DIV_ZERO_ERR_EN
        input  err,
`endif
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output quotient,
        output remainder,
        output busy,
`ifdef DIV_ZERO_ERR_EN
        output err,
`endif
        output done
    );
endinterface

// File: rtl/div_repsub.sv
// div_repsub: sequential unsigned divider using repeated subtraction.
//
// Loads the dividend and then the divisor from bus.data_in on the two cycles
// after start is accepted, then subtracts the divisor once per cycle until the
// remainder is smaller than the divisor. A zero divisor finishes immediately
// with an all-ones quotient and the dividend as remainder.
//
// Optional feature macro: DIV_ZERO_ERR_EN (adds bus.err, high in DONE when the
// captured divisor was zero).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   div_repsub_if.slave: start, data_in -> quotient, remainder, busy,
//         done (and err when DIV_ZERO_ERR_EN is defined)
module div_repsub #(
    parameter int unsigned W = 16
) (
    input logic        clk,
    input logic        rst,
    div_repsub_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LDA  = 3'd1;
    localparam logic [2:0] LDB  = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [2:0]   state_q, state_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] q_q, q_d;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        b_d     = b_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LDA;
            end
            LDA: begin
                r_d     = bus.data_in;
                state_d = LDB;
            end
            LDB: begin
                b_d     = bus.data_in;
                q_d     = '0;
                state_d = SUB;
            end
            SUB: begin
                if (b_q == '0) begin
                    q_d     = '1;
                    state_d = DONE;
                end else if (r_q >= b_q) begin
                    // Compare guards the subtraction, so it never underflows.
                    r_d = r_q - b_q;
                    q_d = q_q + ONE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A level-held start must not launch a second operation.
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            b_q     <= b_d;
            q_q     <= q_d;
        end
    end

    assign bus.quotient  = q_q;
    assign bus.remainder = r_q;
    assign bus.busy      = (state_q == LDA) || (state_q == LDB) || (state_q == SUB);
    assign bus.done      = (state_q == DONE);
`ifdef DIV_ZERO_ERR_EN
    // Divisor register is held through DONE, so it still reflects this operation.
    assign bus.err       = (state_q == DONE) && (b_q == '0);
`endif
endmodule

// File: tb/tb_div_repsub.sv
module tb_div_repsub;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_repsub_if #(.W(W)) bus ();

    div_repsub #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: plain division, independent of the subtraction loop.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.err = 1'b1; e.lat = 4;
        end else begin
            e.q = a / b; e.r = a % b; e.err = 1'b0; e.lat = int'(a / b) + 4;
        end
        return e;
    endfunction

    // Runs one operation from IDLE/DONE; counts edges from e0 (inclusive) until done.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                            input int limit, output int lat, output bit bad_flags,
                            output bit timeout);
        bad_flags = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = W'($urandom);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        bus.data_in = a;
        @(negedge clk);
        bus.data_in = b;
        @(negedge clk);
        bus.data_in = W'($urandom);
        sb.push_back(model(a, b));
        lat = 3;
        while (!bus.done && lat < limit) begin
            if (bus.busy !== 1'b1) bad_flags = 1'b1;
            @(negedge clk);
            lat++;
            if (bus.busy && bus.done) bad_flags = 1'b1;
        end
        timeout = !bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.data_in = 16'h1234;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done} !== {(2*W+2){1'b0}}) begin
            failures++;
            $display("FAIL reset_outputs: got q=%0h r=%0h busy=%b done=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done);
        end
`ifdef DIV_ZERO_ERR_EN
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b want 0", bus.err);
        end
`endif
    endtask

    task automatic test_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int limit);
        int lat; bit bad; bit to; exp_t e;
        drive_op(a, b, 1'b0, limit, lat, bad, to);
        e = sb.pop_front();
        checks++;
        if (to) begin
            failures++;
            $display("FAIL %s_timeout: done not seen after %0d edges, want %0d", name, lat, e.lat);
        end
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat);
        end
        checks++;
        if (bus.quotient !== e.q || bus.remainder !== e.r) begin
            failures++;
            $display("FAIL %s_result: got q=%0d r=%0d want q=%0d r=%0d", name,
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_busy: busy low before done or overlapping done, want clean", name);
        end
`ifdef DIV_ZERO_ERR_EN
        checks++;
        if (bus.err !== e.err) begin
            failures++;
            $display("FAIL %s_err: got %b want %b", name, bus.err, e.err);
        end
`endif
    endtask

    task automatic test_basic();
        test_div("basic_17_5", 16'd17, 16'd5, 100);
        test_div("small_5_17", 16'd5, 16'd17, 100);
        test_div("equal_300_300", 16'd300, 16'd300, 100);
    endtask

    task automatic test_max();
        test_div("max_65535_1", 16'hFFFF, 16'd1, 70000);
    endtask

    task automatic test_div_zero();
        test_div("divzero_42_0", 16'd42, 16'd0, 100);
        test_div("after_zero_42_6", 16'd42, 16'd6, 100);
    endtask

    task automatic test_reset_mid_op();
        int lat; exp_t e;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);                 // after e0
        bus.data_in = 16'd100;
        @(negedge clk);                 // after e1
        bus.data_in = 16'd3;
        repeat (3) @(negedge clk);      // after e2, e3, e4
        checks++;
        if (bus.quotient !== 16'd2 || bus.remainder !== 16'd94 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midop_progress: got q=%0d r=%0d busy=%b want q=2 r=94 busy=1",
                     bus.quotient, bus.remainder, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);                 // after e5
        checks++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done} !== {(2*W+2){1'b0}}) begin
            failures++;
            $display("FAIL midop_reset: got q=%0h r=%0h busy=%b done=%b want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done);
        end
        rst = 1'b0;                     // start still held: fresh run begins next edge
        @(negedge clk);
        bus.data_in = 16'd9;
        @(negedge clk);
        bus.data_in = 16'd4;
        @(negedge clk);
        bus.start = 1'b0;
        sb.push_back(model(16'd9, 16'd4));
        lat = 3;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || bus.quotient !== e.q || bus.remainder !== e.r) begin
            failures++;
            $display("FAIL midop_rerun: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                     lat, bus.quotient, bus.remainder, e.lat, e.q, e.r);
        end
    endtask

    task automatic test_start_held();
        int lat; bit bad; bit to; exp_t e; int stuck;
        drive_op(16'd23, 16'd4, 1'b1, 100, lat, bad, to);
        e = sb.pop_front();
        checks++;
        if (to || bus.quotient !== e.q || bus.remainder !== e.r) begin
            failures++;
            $display("FAIL held_result: got q=%0d r=%0d want q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        stuck = 0;
        for (int i = 0; i < 20; i++) begin
            bus.data_in = W'($urandom);
            @(negedge clk);
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== e.q ||
                bus.remainder !== e.r) stuck++;
        end
        checks++;
        if (stuck != 0) begin
            failures++;
            $display("FAIL held_stable: got %0d unstable cycles want 0", stuck);
        end
        test_div("restart_10_10", 16'd10, 16'd10, 100);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_reset_mid_op();
        test_start_held();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
